// File: rtl/seg_pkg.sv
// Shared types for the display path (binary-to-BCD converter and the
// downstream 7-segment scan driver).
//   bcd_t        one BCD digit
//   SEG_DIGITS   number of digits on the display
//   b2b_state_t  control states of the sequential binary-to-BCD converter
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEG_DIGITS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } b2b_state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
// Pure combinational, 4-bit arithmetic (inputs above 12 wrap, which cannot
// happen for valid BCD).
// Ports:
//   din   in   4  BCD nibble before correction
//   dout  out  4  corrected nibble
module bcd_adj3
  import seg_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  bcd_t sum;

  always_comb begin
    sum  = din + 4'd3;
    dout = (din >= 4'd5) ? sum : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble), one
// input bit per clock. A value is accepted through a valid/ready handshake,
// converted over IN_W cycles, and the result is held on out_bcd/out_ovf
// until the next conversion completes, so the display never glitches.
// Values of 10^DIGITS or more saturate to all nines with out_ovf set.
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         synchronous active-high reset
//   in_valid   in   1         in_data valid
//   in_ready   out  1         idle, can accept in_data
//   in_data    in   IN_W      unsigned binary value
//   out_valid  out  1         one-cycle pulse when out_bcd/out_ovf update
//   out_bcd    out  4*DIGITS  BCD result, nibble k = 10^k digit
//   out_ovf    out  1         last value did not fit (out_bcd saturated)
//   busy       out  1         conversion in progress
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int DIGITS = SEG_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  b2b_state_t state_reg, state_next;

  logic [IN_W-1:0]  bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [BCD_W-1:0] out_bcd_reg;
  logic             out_ovf_reg;
  logic             out_valid_reg;

  // Datapath for one conversion step
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [IN_W-1:0]  bin_shift;
  logic             carry;
  logic             ovf_final;

  // Control strobes
  logic load;
  logic last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .din  (bcd_reg[4*gi +: 4]),
        .dout (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // {carry, bcd, bin} <<= 1 after the per-digit correction. The carry is the
  // bit leaving the top BCD digit: any 1 there means the value needs more
  // than DIGITS decimal digits.
  always_comb begin
    carry     = bcd_adj[BCD_W-1];
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[IN_W-1]};
    bin_shift = {bin_reg[IN_W-2:0], 1'b0};
    ovf_final = ovf_reg | carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    load       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == CNT_W'(1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg       <= '0;
      bcd_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      out_bcd_reg   <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= last;
      if (load) begin
        bin_reg <= in_data;
        bcd_reg <= '0;
        ovf_reg <= 1'b0;
        cnt_reg <= CNT_W'(IN_W);
      end else if (state_reg == CONV) begin
        bin_reg <= bin_shift;
        bcd_reg <= bcd_shift;
        ovf_reg <= ovf_final;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      // Result registers move only on the final shift; this cycle's carry
      // is included through ovf_final.
      if (last) begin
        out_bcd_reg <= ovf_final ? {DIGITS{4'h9}} : bcd_shift;
        out_ovf_reg <= ovf_final;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_bcd   = out_bcd_reg;
  assign out_ovf   = out_ovf_reg;
  assign busy      = ~in_ready;

endmodule
